// File: rtl/dm_resp_pkg.sv
// Shared types and helpers for the data-memory responder and its word storage.
package dm_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    localparam int WORD_BYTES = 4;

    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_SET  = 1'b1;

    // Word-index width; a floor of one bit keeps port vectors legal.
    function automatic int addr_idx_w(input int depthWords);
        return (depthWords > 1) ? $clog2(depthWords) : 1;
    endfunction

endpackage

// File: rtl/dm_word_array.sv
// Word storage built from one byte-wide array per lane: synchronous write with
// per-lane enables, combinational read.
module dm_word_array
    import dm_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] byteEn,
    input  logic [IDX_W-1:0]      wrIdx,
    input  logic [31:0]           wrData,
    input  logic [IDX_W-1:0]      rdIdx,
    output logic [31:0]           rdData
);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : gLane
            logic [7:0] laneMem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (we && byteEn[gi]) begin
                    laneMem[wrIdx] <= wrData[8*gi +: 8];
                end
            end

            assign rdData[8*gi +: 8] = laneMem[rdIdx];
        end
    endgenerate

endmodule

// File: rtl/dm_responder.sv
// Target end of the MEM-stage load/store handshake: one request at a time,
// fixed LATENCY, registered response. DM_BYTE_MASK_EN adds per-byte store enables.
module dm_responder
    import dm_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DM_BYTE_MASK_EN
    input  logic [3:0]  req_be,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W    = addr_idx_w(DEPTH_WORDS);
    localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;

    dm_state_t             stateReg;
    logic [CNT_W-1:0]      cntReg;
    logic                  reqReadyReg;
    logic                  respValidReg;
    logic [31:0]           rdataReg;
    logic                  errReg;

    logic                  latWrite;
    logic [31:0]           latAddr;
    logic [31:0]           latWdata;
    logic [WORD_BYTES-1:0] latBe;

    logic                  opWrite;
    logic [31:0]           opAddr;
    logic [31:0]           opWdata;
    logic [WORD_BYTES-1:0] opBe;
    logic                  opErr;
    logic                  enterResp;
    logic                  arrWe;
    logic [31:0]           arrRdata;
    logic [31:0]           rdataNext;
    logic                  errNext;
    logic [WORD_BYTES-1:0] reqBeInt;

`ifdef DM_BYTE_MASK_EN
    assign reqBeInt = req_be;
`else
    assign reqBeInt = '1;
`endif

    // With LATENCY=1 the op happens on the acceptance edge, so it must use
    // the live request rather than the latched copy.
    always_comb begin
        opWrite = latWrite;
        opAddr  = latAddr;
        opWdata = latWdata;
        opBe    = latBe;
        if (stateReg == IDLE) begin
            opWrite = req_write;
            opAddr  = req_addr;
            opWdata = req_wdata;
            opBe    = reqBeInt;
        end
    end

    assign opErr = (opAddr[1:0] != 2'b00) ||
                   ({2'b00, opAddr[31:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        enterResp = 1'b0;
        case (stateReg)
            IDLE:    enterResp = req_valid && (LATENCY == 1);
            BUSY:    enterResp = (cntReg == '0);
            default: enterResp = 1'b0;
        endcase
    end

    // rst_n gate keeps a held reset from committing a LATENCY=1 store.
    assign arrWe     = rst_n && enterResp && opWrite && !opErr;
    assign rdataNext = (opWrite || opErr) ? 32'h0 : arrRdata;
    assign errNext   = opErr ? ERR_SET : ERR_NONE;

    dm_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) uArray (
        .clk   (clk),
        .we    (arrWe),
        .byteEn(opBe),
        .wrIdx (opAddr[IDX_W+1:2]),
        .wrData(opWdata),
        .rdIdx (opAddr[IDX_W+1:2]),
        .rdData(arrRdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= IDLE;
            cntReg       <= '0;
            reqReadyReg  <= 1'b1;
            respValidReg <= 1'b0;
            rdataReg     <= 32'h0;
            errReg       <= ERR_NONE;
            latWrite     <= 1'b0;
            latAddr      <= 32'h0;
            latWdata     <= 32'h0;
            latBe        <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (req_valid) begin
                        latWrite    <= req_write;
                        latAddr     <= req_addr;
                        latWdata    <= req_wdata;
                        latBe       <= reqBeInt;
                        reqReadyReg <= 1'b0;
                        if (LATENCY == 1) begin
                            stateReg     <= RESP;
                            respValidReg <= 1'b1;
                            rdataReg     <= rdataNext;
                            errReg       <= errNext;
                        end else begin
                            stateReg <= BUSY;
                            cntReg   <= CNT_W'(CNT_INIT);
                        end
                    end
                end
                BUSY: begin
                    if (cntReg == '0) begin
                        stateReg     <= RESP;
                        respValidReg <= 1'b1;
                        rdataReg     <= rdataNext;
                        errReg       <= errNext;
                    end else begin
                        cntReg <= cntReg - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        stateReg     <= IDLE;
                        respValidReg <= 1'b0;
                        errReg       <= ERR_NONE;
                        reqReadyReg  <= 1'b1;
                    end
                end
                default: begin
                    stateReg     <= IDLE;
                    reqReadyReg  <= 1'b1;
                    respValidReg <= 1'b0;
                    errReg       <= ERR_NONE;
                end
            endcase
        end
    end

    assign req_ready  = reqReadyReg;
    assign resp_valid = respValidReg;
    assign resp_rdata = rdataReg;
    assign resp_err   = errReg;

endmodule
